irq_ctrl: RTL
=============

# irq_ctrl

Parametrised multi-channel interrupt controller for the MIPS CPU. It replaces the single `IRQ`/supervisor gating in the control decoder with:

- per-channel edge capture and pending latches;
- a software-writable mask;
- fixed-priority selection;
- a request/service state machine that prevents nesting.

Its `interrupt` output drives the decoder's interrupt path (PCSrc = 4, RegDst/MemToReg = 2'b11/2'b10).

## Interface
- `N_IRQ`, default 8: number of interrupt channels, 1..32.
- `ID_W`, default `$clog2(N_IRQ)` (minimum 1): width of the channel index.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_in`  in  N_IRQ  level interrupt lines; a rising edge raises a request.
- `kernel`  in  1  CPU in supervisor mode (PC[31]); blocks new requests.
- `mask_we`  in  1  mask write strobe.
- `mask_wdata`  in  N_IRQ  new mask; bit = 1 enables the channel.
- `take_ack`  in  1  CPU has committed the interrupt jump this cycle.
- `eret`  in  1  handler return executed.
- `interrupt`  out  1  request to control decoder (registered).
- `irq_id`  out  ID_W  index of the channel being requested or serviced.
- `pending`  out  N_IRQ  pending latch contents.
- `mask`  out  N_IRQ  current mask.
- `busy`  out  1  state is SERVICE.

## Operation
- Edge detect:
  - `irq_q <= irq_in` every cycle.
  - `rise = irq_in & ~irq_q`.
- Pending:
  - Update: `pending <= (pending & ~clr) | rise`.
  - `clr` is a one-hot of `irq_id`, asserted only on the cycle the FSM leaves REQ via `take_ack`.
  - On a same-cycle set and clear of one bit, set wins.
- Request vector:
  - `req = pending & mask`.
  - The selected channel is the lowest set index of `req` (channel 0 has highest priority).
- States:
  - **IDLE**
    - Go to REQ when `req != 0` and `kernel == 0`.
    - Latch `irq_id` = selected channel.
  - **REQ**
    - `interrupt = 1`.
    - `take_ack` → SERVICE, and clear the pending bit of `irq_id`.
    - Else, if `mask[irq_id]` or `pending[irq_id]` is 0 → IDLE (request withdrawn).
    - `irq_id` is held stable while in REQ.
  - **SERVICE**
    - `interrupt = 0`, `busy = 1`.
    - `eret` → IDLE. New edges still set pending bits.
    - No nesting: no request is raised until IDLE.
- `take_ack` outside REQ and `eret` outside SERVICE are ignored.
- Mask:
  - `mask_we` loads `mask_wdata` at the clock edge.
  - The new mask affects `req` from the next cycle.
- Reset values:
  - state = IDLE, `interrupt = 0`, `busy = 0`, `irq_id = 0`.
  - `pending = 0`, `mask = 0`.
  - `irq_q = 0`, so a line already high when reset releases is seen as an edge.

## Timing
- Edge to pending:
  - `irq_in` is sampled high at edge t, having been low at t−1.
  - Its `pending` bit is 1 after edge t.
- Pending to interrupt:
  - `interrupt` is 1 after edge t+1, provided the channel is unmasked, `kernel = 0`, and state = IDLE.
  - Total latency is 2 cycles.
- Ack:
  - `take_ack` sampled at edge u: `interrupt = 0`, `busy = 1`, and the pending bit is cleared, all after edge u.
- Return:
  - `eret` at edge v gives IDLE after v.
  - If `req != 0`, `interrupt` is reasserted after v+1.
- Withdrawal:
  - Masking `irq_id` while in REQ drops `interrupt` 2 edges after `mask_we` (mask update, then state update).
  - `take_ack` in that same window still wins.
- Reset during REQ or SERVICE: everything returns to reset values after the edge.

## Configuration
- `IRQ_SYNC_EN` defined:
  - A two-flop synchronizer is inserted on `irq_in` ahead of the edge detect.
  - Edge-to-interrupt latency becomes 4 cycles.
  - The synchronizer flops reset to 0.
- `IRQ_SYNC_EN` undefined:
  - `irq_in` is assumed synchronous to `clk`.
  - Latency is as in Timing.

## Structure
- Shared package:
  - FSM state typedef: IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2.
  - The PCSrc interrupt code constant 3'd4, shared with the control decoder.
- Sub-module `irq_prio_enc`:
  - Parametrised by `N_IRQ`.
  - Input: request vector. Outputs: `valid` and the lowest-set-index `id`.
  - Purely combinational, instantiated once.

## Test plan
- N_IRQ=8, mask=8'hFF, rising edge on `irq_in[3]` at cycle 10:
  - `pending = 8'h08` after cycle 10.
  - `interrupt = 1`, `irq_id = 3` after cycle 11.
- Edges on channels 5 and 2 in the same cycle:
  - `irq_id = 2`.
  - After `take_ack`, `pending = 8'h20`.
  - After `eret`, `interrupt` reasserts with `irq_id = 5`.
- `kernel = 1` with `pending = 8'h01`, mask = 8'hFF:
  - `interrupt` stays 0.
  - Deassert `kernel`: `interrupt = 1` one cycle later.
- In SERVICE for channel 4, edge on channel 0:
  - `pending[0]` sets, `interrupt` stays 0.
  - After `eret`: `irq_id = 0`.
- In REQ for channel 1, write mask = 8'hFD:
  - `interrupt` drops after 2 edges; `pending[1]` is still 1.
  - Restore mask = 8'hFF: request returns.
- Assert `reset` while in SERVICE with pending = 8'hF0: all outputs are 0 after the edge.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller and the control decoder.
package irq_ctrl_pkg;

  typedef logic [1:0] irq_state_t;

  localparam irq_state_t IDLE    = 2'd0;
  localparam irq_state_t REQ     = 2'd1;
  localparam irq_state_t SERVICE = 2'd2;

  // PCSrc selector the control decoder uses for the interrupt vector.
  localparam logic [2:0] PCSRC_IRQ = 3'd4;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of the request vector.
module irq_prio_enc #(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Multi-channel interrupt controller: edge capture, mask, priority select, no nesting.
// Define IRQ_SYNC_EN to insert a two-flop synchronizer on irq_in.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             kernel,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             take_ack,
  input  logic             eret,
  output logic             interrupt,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             busy
);

  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] req;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  enc_id;
  logic             enc_valid;
  irq_state_t       state_q, state_d;
  logic             interrupt_q, interrupt_d;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign rise = irq_s & ~irq_q;
  assign req  = pending_q & mask_q;

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (req),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (enc_valid && !kernel) begin
          state_d = REQ;
          id_d    = enc_id;
        end
      end
      REQ: begin
        if (take_ack) begin
          state_d     = SERVICE;
          clr[id_q]   = 1'b1;
        end else if (!mask_q[id_q] || !pending_q[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge on the channel being cleared keeps its pending bit set.
  assign pending_d   = (pending_q & ~clr) | rise;
  assign mask_d      = mask_we ? mask_wdata : mask_q;
  assign interrupt_d = (state_d == REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q       <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      id_q        <= '0;
      state_q     <= IDLE;
      interrupt_q <= 1'b0;
    end else begin
      irq_q       <= irq_s;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      id_q        <= id_d;
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign interrupt = interrupt_q;
  assign irq_id    = id_q;
  assign pending   = pending_q;
  assign mask      = mask_q;
  assign busy      = (state_q == SERVICE);

endmodule
